// File: rtl/picomips_pkg.sv
// Shared picoMIPS types and constants: sequencer state encoding and default program address width.
package picomips_pkg;

    localparam int unsigned PSIZE_DEF = 6;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_MUL  = 2'd2,
        S_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next program counter: absolute jump, PC-relative branch or increment.
module pc_next_calc
    import picomips_pkg::*;
#(
    parameter int unsigned Psize = PSIZE_DEF
) (
    input  logic [Psize-1:0] address,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic [Psize-1:0] target,
    output logic [Psize-1:0] next_pc
);

    // At equal width the sign-extended offset add is a plain modulo-2^Psize add.
    always_comb begin
        next_pc = address + Psize'(1);
        if (jump_en) begin
            next_pc = target;
        end else if (branch_en) begin
            next_pc = address + target;
        end
    end

endmodule

// File: rtl/picomips_fetch_ctrl.sv
// picoMIPS program sequencer: owns the PC, stalls for multiply and external input, handles halt.
module picomips_fetch_ctrl
    import picomips_pkg::*;
#(
    parameter int unsigned Psize     = PSIZE_DEF,
    parameter int unsigned MulCycles = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             halt_req,
    input  logic             wait_req,
    input  logic             in_valid,
    input  logic             mul_req,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic [Psize-1:0] target,
    output logic [Psize-1:0] address,
    output logic             commit,
    output logic             in_ack,
    output logic             busy,
    output logic             halted
);

    localparam int unsigned CNT_W = 4;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [Psize-1:0]   address_q, address_d;
    logic [Psize-1:0]   next_pc;

    pc_next_calc #(.Psize(Psize)) u_pc_next_calc (
        .address   (address_q),
        .jump_en   (jump_en),
        .branch_en (branch_en),
        .target    (target),
        .next_pc   (next_pc)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            address_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
        end
    end

    // The PC only moves on a retiring cycle, so address tracks commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        address_d = commit ? next_pc : address_q;
        if (en) begin
            case (state_q)
                S_RUN: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (wait_req) begin
                        if (!in_valid) state_d = S_WAIT;
                    end else if (mul_req) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(MulCycles - 1);
                    end
                end
                S_WAIT: begin
                    if (in_valid) state_d = S_RUN;
                end
                S_MUL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    // Mealy strobes; everything reads idle while Reset is asserted.
    always_comb begin
        commit = 1'b0;
        in_ack = 1'b0;
        busy   = 1'b0;
        halted = 1'b0;
        if (!Reset) begin
            busy   = (state_q == S_WAIT) || (state_q == S_MUL);
            halted = (state_q == S_HALT);
            if (en) begin
                case (state_q)
                    S_RUN: begin
                        if (halt_req) begin
                            commit = 1'b0;
                        end else if (wait_req) begin
                            commit = in_valid;
                            in_ack = in_valid;
                        end else if (!mul_req) begin
                            commit = 1'b1;
                        end
                    end
                    S_WAIT: begin
                        commit = in_valid;
                        in_ack = in_valid;
                    end
                    S_MUL: begin
                        commit = (cnt_q == '0);
                    end
                    S_HALT: begin
                        commit = 1'b0;
                    end
                endcase
            end
        end
    end

    assign address = address_q;

endmodule
